// File: rtl/serial_port_demux.sv
// Serial frame demultiplexer: start bit, port address, payload length, then LEN payload
// bits steered to one of 2**PORT_W serial outputs. Optional parity: SERIAL_PORT_DEMUX_PARITY_EN.
module serial_port_demux #(
    parameter int PORT_W = 2,
    parameter int LEN_W = 4,
    localparam int N_PORTS = 2 ** PORT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clkEn,
    input  logic               SerIn,
    output logic [N_PORTS-1:0] SerOut,
    output logic [N_PORTS-1:0] OutValid,
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
    output logic               ParityErr,
`endif
    output logic               Done,
    output logic               Busy
);

    localparam int BC_W = (PORT_W > LEN_W) ? PORT_W : LEN_W;

`ifdef SERIAL_PORT_DEMUX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_LEN    = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_LEN  = 2'd2,
        S_DATA = 2'd3
    } state_t;
`endif

    state_t              state_q;
    state_t              state_d;
    logic [PORT_W-1:0]   addr_q;
    logic [PORT_W-1:0]   addr_d;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_d;
    logic [BC_W-1:0]     bitcnt_q;
    logic [BC_W-1:0]     bitcnt_d;
    logic [LEN_W-1:0]    datacnt_q;
    logic [LEN_W-1:0]    datacnt_d;
    logic [N_PORTS-1:0]  ser_out_q;
    logic [N_PORTS-1:0]  ser_out_d;
    logic [N_PORTS-1:0]  out_valid_q;
    logic [N_PORTS-1:0]  out_valid_d;

    // Shift-in values written as shift-or so PORT_W or LEN_W of 1 stays legal.
    logic [PORT_W-1:0]   addr_next;
    logic [LEN_W-1:0]    len_next;

    assign addr_next = (addr_q << 1) | PORT_W'(SerIn);
    assign len_next  = (len_q << 1) | LEN_W'(SerIn);

`ifdef SERIAL_PORT_DEMUX_PARITY_EN
    logic par_q;
    logic par_d;
    logic perr_q;
    logic perr_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            bitcnt_q    <= '0;
            datacnt_q   <= '0;
            ser_out_q   <= '0;
            out_valid_q <= '0;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
            par_q       <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            bitcnt_q    <= bitcnt_d;
            datacnt_q   <= datacnt_d;
            ser_out_q   <= ser_out_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
            par_q       <= par_d;
            perr_q      <= perr_d;
`endif
        end
    end

    // Strobes default to 0 every edge so each one lasts exactly one clk even with a divided clkEn.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        bitcnt_d    = bitcnt_q;
        datacnt_d   = datacnt_q;
        ser_out_d   = ser_out_q;
        out_valid_d = '0;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
        par_d       = par_q;
        perr_d      = 1'b0;
`endif
        if (clkEn) begin
            case (state_q)
                S_IDLE: begin
                    if (!SerIn) begin
                        state_d  = S_ADDR;
                        bitcnt_d = '0;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
                        par_d    = 1'b0;
`endif
                    end
                end
                S_ADDR: begin
                    addr_d = addr_next;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
                    par_d  = par_q ^ SerIn;
`endif
                    if (bitcnt_q == BC_W'(PORT_W - 1)) begin
                        state_d  = S_LEN;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + BC_W'(1);
                    end
                end
                S_LEN: begin
                    len_d = len_next;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
                    par_d = par_q ^ SerIn;
`endif
                    if (bitcnt_q == BC_W'(LEN_W - 1)) begin
                        bitcnt_d = '0;
                        if (len_next != '0) begin
                            state_d   = S_DATA;
                            datacnt_d = len_next;
                        end else begin
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_IDLE;
`endif
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BC_W'(1);
                    end
                end
                S_DATA: begin
                    ser_out_d[addr_q]   = SerIn;
                    out_valid_d[addr_q] = 1'b1;
                    datacnt_d           = datacnt_q - LEN_W'(1);
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
                    par_d               = par_q ^ SerIn;
`endif
                    if (datacnt_q == LEN_W'(1)) begin
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
                S_PARITY: begin
                    // Even parity: the accumulated bits XOR the parity bit must be zero.
                    perr_d  = par_q ^ SerIn;
                    state_d = S_IDLE;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign SerOut   = ser_out_q;
    assign OutValid = out_valid_q;
    assign Done     = (state_q == S_IDLE);
    assign Busy     = ~Done;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
    assign ParityErr = perr_q;
`endif

endmodule

// File: tb/tb_serial_port_demux.sv
// Bench for serial_port_demux: frames are built from their field values and every clk edge
// is checked against a frame-level model of the port outputs and Done/Busy.
module tb_serial_port_demux;

    localparam int PORT_W  = 2;
    localparam int LEN_W   = 4;
    localparam int N_PORTS = 2 ** PORT_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clkEn = 1'b0;
    logic               SerIn = 1'b1;
    logic [N_PORTS-1:0] SerOut;
    logic [N_PORTS-1:0] OutValid;
    logic               Done;
    logic               Busy;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
    logic               ParityErr;
`endif

    serial_port_demux #(.PORT_W(PORT_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clkEn    (clkEn),
        .SerIn    (SerIn),
        .SerOut   (SerOut),
        .OutValid (OutValid),
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
        .ParityErr(ParityErr),
`endif
        .Done     (Done),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [N_PORTS-1:0] ser_model;
    logic               done_model;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic [N_PORTS-1:0] exp_valid, input logic exp_perr);
        check("out_valid", 32'(OutValid), 32'(exp_valid));
        check("ser_out", 32'(SerOut), 32'(ser_model));
        check("done", 32'(Done), 32'(done_model));
        check("busy", 32'(Busy), 32'(!done_model));
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
        check("parity_err", 32'(ParityErr), 32'(exp_perr));
`else
        if (exp_perr) check("parity_err_expected", 32'(1), 32'(0));
`endif
    endtask

    // One clk edge with the given inputs, then compare outputs just after the edge.
    task automatic edge_step(input logic b, input logic en,
                             input logic [N_PORTS-1:0] exp_valid, input logic exp_perr);
        SerIn = b;
        clkEn = en;
        @(posedge clk);
        #1;
        check_outputs(exp_valid, exp_perr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) edge_step(1'b1, logic'($urandom_range(0, 1)), '0, 1'b0);
    endtask

    task automatic abort_with_reset();
        #2;
        rst_n = 1'b0;
        #1;
        ser_model  = '0;
        done_model = 1'b1;
        check("rst_out_valid", 32'(OutValid), 32'(0));
        check("rst_ser_out", 32'(SerOut), 32'(0));
        check("rst_done", 32'(Done), 32'(1));
        check("rst_busy", 32'(Busy), 32'(0));
        SerIn = 1'b1;
        clkEn = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    // kind: 0 start, 1 header (addr/len), 2 payload, 3 parity
    task automatic send_frame(input int port, input int len, input int data, input int period,
                              input int abort_idx, input bit bad_par);
        logic               bits[$];
        int                 kind[$];
        logic               par;
        logic               b;
        logic               en;
        logic [N_PORTS-1:0] ev;
        logic               ep;
        int                 di;
        par = 1'b0;
        di  = 0;
        bits.push_back(1'b0);
        kind.push_back(0);
        for (int i = PORT_W - 1; i >= 0; i--) begin
            bits.push_back(port[i]);
            kind.push_back(1);
            par ^= port[i];
        end
        for (int i = LEN_W - 1; i >= 0; i--) begin
            bits.push_back(len[i]);
            kind.push_back(1);
            par ^= len[i];
        end
        for (int i = len - 1; i >= 0; i--) begin
            bits.push_back(data[i]);
            kind.push_back(2);
            par ^= data[i];
        end
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
        bits.push_back(par ^ bad_par);
        kind.push_back(3);
`endif
        for (int k = 0; k < bits.size(); k++) begin
            if (kind[k] == 2 && di == abort_idx) begin
                abort_with_reset();
                return;
            end
            for (int c = 0; c < period; c++) begin
                en = (c == period - 1);
                b  = en ? bits[k] : logic'($urandom_range(0, 1));
                ev = '0;
                ep = 1'b0;
                if (en) begin
                    if (k == 0) done_model = 1'b0;
                    if (kind[k] == 2) begin
                        ev[port]        = 1'b1;
                        ser_model[port] = bits[k];
                    end
                    if (kind[k] == 3) ep = bad_par;
                    if (k == bits.size() - 1) done_model = 1'b1;
                end
                edge_step(b, en, ev, ep);
            end
            if (kind[k] == 2) di++;
        end
    endtask

    initial begin
        ser_model  = '0;
        done_model = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs('0, 1'b0);
        rst_n = 1'b1;
        idle(2);

        send_frame(2, 3, 5, 1, -1, 1'b0);
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
        send_frame(2, 3, 5, 1, -1, 1'b1);
`endif
        idle(1);
        send_frame(3, 0, 0, 1, -1, 1'b0);
        idle(2);
        send_frame(2, 3, 5, 4, -1, 1'b0);
        idle(1);
        send_frame(1, 1, 1, 1, -1, 1'b0);
        send_frame(3, 2, 1, 1, -1, 1'b0);
        idle(2);
        send_frame(1, 5, 22, 1, 1, 1'b0);
        send_frame(0, 4, 9, 1, -1, 1'b0);
        idle(1);

        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(0, N_PORTS - 1), $urandom_range(0, 2 ** LEN_W - 1),
                       int'($urandom), $urandom_range(1, 3), -1, bit'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
